param_counter_scan: RTL and testbench
=====================================

Name: param_counter_scan

Overview:
- Parametrised successor of the 4-bit scan counter: WIDTH-bit up/down counter with enable, parallel load and terminal-count flag.
- The count register is split into NUM_CHAINS independent scan segments, shifted in parallel.
- A shift tracker pulses shift_done when a full segment has been shifted, so the test controller can sequence load, capture and unload without external cycle counting.
- Sits under the DFT test wrapper as the reference scannable counter for ATPG flow bring-up.

Parameters:
- WIDTH, 8, counter width in bits; must be ≥ 2.
- NUM_CHAINS, 2, number of scan segments; must divide WIDTH. CHAIN_LEN = WIDTH/NUM_CHAINS is derived, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- scan_en  input  1  1 = shift mode, 0 = functional mode.
- scan_in  input  NUM_CHAINS  serial input, bit k feeds segment k.
- scan_out  output  NUM_CHAINS  serial output, bit k = MSB of segment k.
- cnt_en  input  1  functional count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  parallel load value.
- count  output  WIDTH  counter register.
- tc  output  1  terminal count flag.
- shift_done  output  1  one-cycle pulse, segment fully shifted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=0, internal shift counter=0, shift_done=0, state=FUNC.
  - Reset has priority over all inputs, including mid-shift.
- Priority per edge: rst > scan_en > load > cnt_en > hold.
- Functional mode (scan_en=0):
  - load=1: count<=load_val.
  - Else cnt_en=1: count<=count+1 if up_dn=1, count-1 if up_dn=0, modulo 2^WIDTH. So all-ones+1 → 0 and 0−1 → all-ones.
  - Else hold.
- tc is combinational: 1 when cnt_en=1, scan_en=0 and load=0, and either (up_dn=1 and count=all-ones) or (up_dn=0 and count=0). Otherwise 0.
- Scan segments:
  - Segment k = count[k*CHAIN_LEN +: CHAIN_LEN].
  - On each edge with scan_en=1, the segment shifts toward its MSB, and bit k*CHAIN_LEN loads scan_in[k].
  - scan_out[k] = count[k*CHAIN_LEN+CHAIN_LEN-1], combinational from the register. The old MSB is visible before the edge that discards it.
  - After CHAIN_LEN shifts with serial sequence b0,b1,...: segment MSB=b0, LSB=b(CHAIN_LEN−1). Example with CHAIN_LEN=4: shifting 1,0,1,0 gives segment 1010.
- FSM (states FUNC, SHIFT):
  - FUNC→SHIFT on an edge with scan_en=1. SHIFT→FUNC on an edge with scan_en=0.
  - The shift counter (width clog2(CHAIN_LEN+1)) increments on every shift edge.
  - When it reaches CHAIN_LEN, shift_done is registered high for exactly the following cycle and the counter returns to 0. Consecutive full segments therefore produce a pulse every CHAIN_LEN shifts.
- scan_en dropped mid-segment:
  - Shift counter clears to 0, no shift_done pulse.
  - Partially shifted contents remain in count; functional operation resumes from them next edge.
- load/cnt_en/up_dn are ignored while scan_en=1.
- No X propagation from load_val when load=0.

Optional Feature:
- Macro COUNT_SAT_EN.
- Defined: counting saturates. Up-count at all-ones holds all-ones; down-count at 0 holds 0. tc behaviour is unchanged, so it still flags the boundary.
- Undefined: modulo wrap as above.
- Scan shifting and load are unaffected either way.

Decomposition:
- Package pcs_pkg:
  - state enum {FUNC, SHIFT}.
  - function clog2.
  - elaboration-check macro/assertion that WIDTH % NUM_CHAINS == 0.
- One sub-module, scan_shift_tracker (params CHAIN_LEN; ports clk, rst, scan_en, shift_done). Owns the FSM and shift counter.
- The counter datapath and segment shifting stay in param_counter_scan, built with a generate loop over chains.

Test Plan (WIDTH=8, NUM_CHAINS=2):
- rst=1 two edges, then release with cnt_en=1, up_dn=1, five edges → count 0,1,2,3,4,5; tc=0; shift_done never asserted.
- load=1, load_val=8'hFE, then cnt_en=1, up_dn=1 → count FE, tc=0; count FF, tc=1; count 00 (with COUNT_SAT_EN: stays FF, tc=1). Then up_dn=0 from 00 → tc=1, next count FF.
- scan_en=1, scan_in[0] sequence 1,0,1,0 and scan_in[1] sequence 0,1,1,0, from count=8'h00 → count=8'h6A. shift_done=1 exactly in the cycle after the 4th shift. scan_out before each edge equals the prior segment MSBs.
- Unload: count=8'hC3, scan_en=1 for 4 edges with scan_in=0 → scan_out[1] sequence 1,1,0,0 and scan_out[0] sequence 0,0,1,1; final count=8'h00; one shift_done pulse.
- Drop scan_en after 2 of 4 shifts (scan_in=2'b11 from 8'h00) → count=8'h33, no shift_done. A new scan burst needs a full 4 shifts before shift_done.
- rst=1 asserted mid-shift (after 3 shifts) → count=0, shift_done=0, state FUNC, even with scan_en still 1 at that edge.

Source files
------------

// File: rtl/pcs_pkg.sv
// ============================================================================
// Module      : pcs_pkg
// Description : Shared types and elaboration helpers for param_counter_scan.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcs_pkg;

    typedef enum logic [0:0] {
        FUNC  = 1'b0,
        SHIFT = 1'b1
    } pcs_state_e;

    // Ceiling log2, valid for value >= 1 (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit chains_divide(input int width, input int num_chains);
        return (width >= 2) && (num_chains > 0) && ((width % num_chains) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_shift_tracker.sv
// ============================================================================
// Module      : scan_shift_tracker
// Description : FUNC/SHIFT state machine; pulses shift_done after every
//               CHAIN_LEN consecutive shift cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_shift_tracker
    import pcs_pkg::*;
#(
    parameter int CHAIN_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic scan_en,
    output logic shift_done
);

    localparam int              CNT_W  = clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CHAIN_LEN);

    pcs_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] w_cnt_inc;

    // A burst entered from FUNC always starts counting from zero.
    assign w_cnt_inc = ((state_q == SHIFT) ? cnt_q : '0) + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            FUNC, SHIFT: begin
                if (scan_en) begin
                    state_d = SHIFT;
                    if (w_cnt_inc == C_LAST) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end else begin
                    state_d = FUNC;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = FUNC;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FUNC;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign shift_done = done_q;

endmodule

`default_nettype wire

// File: rtl/param_counter_scan.sv
// ============================================================================
// Module      : param_counter_scan
// Description : WIDTH-bit up/down/load counter with terminal count, scanned
//               as NUM_CHAINS parallel segments. Optional macro COUNT_SAT_EN
//               makes counting saturate instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_counter_scan
    import pcs_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_CHAINS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_en,
    input  logic [NUM_CHAINS-1:0] scan_in,
    output logic [NUM_CHAINS-1:0] scan_out,
    input  logic                  cnt_en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  shift_done
);

    localparam int CHAIN_LEN = WIDTH / NUM_CHAINS;

    generate
        if (!chains_divide(WIDTH, NUM_CHAINS)) begin : g_param_check
            $error("param_counter_scan: WIDTH must be >= 2 and divisible by NUM_CHAINS");
        end
    endgenerate

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] w_shift_val;
    logic [WIDTH-1:0] w_inc, w_dec;
    logic             w_at_max, w_at_zero;

    generate
        for (genvar k = 0; k < NUM_CHAINS; k++) begin : g_chain
            if (CHAIN_LEN == 1) begin : g_len1
                assign w_shift_val[k] = scan_in[k];
            end else begin : g_lenn
                assign w_shift_val[k*CHAIN_LEN +: CHAIN_LEN] =
                    {count_q[k*CHAIN_LEN +: CHAIN_LEN-1], scan_in[k]};
            end
            assign scan_out[k] = count_q[k*CHAIN_LEN + CHAIN_LEN - 1];
        end
    endgenerate

    assign w_inc     = count_q + WIDTH'(1);
    assign w_dec     = count_q - WIDTH'(1);
    assign w_at_max  = &count_q;
    assign w_at_zero = ~|count_q;

    assign tc = cnt_en & ~scan_en & ~load & (up_dn ? w_at_max : w_at_zero);

    always_comb begin
        count_d = count_q;
        if (scan_en) begin
            count_d = w_shift_val;
        end else if (load) begin
            count_d = load_val;
        end else if (cnt_en) begin
`ifdef COUNT_SAT_EN
            if (up_dn && !w_at_max) begin
                count_d = w_inc;
            end else if (!up_dn && !w_at_zero) begin
                count_d = w_dec;
            end
`else
            count_d = up_dn ? w_inc : w_dec;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

    scan_shift_tracker #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .scan_en    (scan_en),
        .shift_done (shift_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_param_counter_scan.sv
// ============================================================================
// Module      : tb_param_counter_scan
// Description : Table-driven, scoreboarded bench for param_counter_scan
//               (WIDTH=8, NUM_CHAINS=2), wrap or COUNT_SAT_EN build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_counter_scan;

    logic       clk = 1'b0;
    logic       rst, scan_en, cnt_en, up_dn, load;
    logic [1:0] scan_in, scan_out;
    logic [7:0] load_val, count;
    logic       tc, shift_done;

    always #5 clk = ~clk;

    param_counter_scan #(
        .WIDTH      (8),
        .NUM_CHAINS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_en    (scan_en),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .cnt_en     (cnt_en),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .count      (count),
        .tc         (tc),
        .shift_done (shift_done)
    );

`ifdef COUNT_SAT_EN
    localparam logic [7:0] C_TOP_NEXT  = 8'hFF;
    localparam logic [7:0] C_ZERO_NEXT = 8'h00;
    localparam logic [1:0] C_SO_V11    = 2'b11;
    localparam logic [1:0] C_SO_V13    = 2'b00;
`else
    localparam logic [7:0] C_TOP_NEXT  = 8'h00;
    localparam logic [7:0] C_ZERO_NEXT = 8'hFF;
    localparam logic [1:0] C_SO_V11    = 2'b00;
    localparam logic [1:0] C_SO_V13    = 2'b11;
`endif

    typedef struct {
        logic       rst, se;
        logic [1:0] si;
        logic       ce, ud, ld;
        logic [7:0] lv;
        logic       pre;
        logic       e_tc;
        logic [1:0] e_so;
        logic [7:0] e_cnt;
        logic       e_sd;
    } vec_t;

    typedef struct {
        logic [7:0] cnt;
        logic       sd;
        int         idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic r, logic se, logic [1:0] si, logic ce, logic ud,
                                logic ld, logic [7:0] lv, logic pre, logic e_tc,
                                logic [1:0] e_so, logic [7:0] e_cnt, logic e_sd);
        vec_t v;
        v.rst = r;  v.se = se; v.si = si; v.ce = ce; v.ud = ud; v.ld = ld; v.lv = lv;
        v.pre = pre; v.e_tc = e_tc; v.e_so = e_so; v.e_cnt = e_cnt; v.e_sd = e_sd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic se, input logic [1:0] si, input logic ce,
                         input logic ud, input logic ld, input logic [7:0] lv);
        rst = r; scan_en = se; scan_in = si; cnt_en = ce; up_dn = ud; load = ld; load_val = lv;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   first_at, second_at;
        exp_t e;

        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);

        // reset, then count up 1..5
        tbl.push_back(mk(1,0,2'b00,0,0,0,8'h00, 0,0,2'b00,8'h00,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0,8'h00, 1,0,2'b00,8'h00,0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(0,0,2'b00,1,1,0,8'h00, 1,0,2'b00,8'(i),0));
        // load and terminal-count boundaries
        tbl.push_back(mk(0,0,2'b00,1,1,1,8'hFE, 1,0,2'b00,8'hFE,0));
        tbl.push_back(mk(0,0,2'b00,1,1,0,8'h00, 1,0,2'b11,8'hFF,0));
        tbl.push_back(mk(0,0,2'b00,1,1,0,8'h00, 1,1,2'b11,C_TOP_NEXT,0));
        tbl.push_back(mk(0,0,2'b00,1,0,1,8'h00, 1,0,C_SO_V11,8'h00,0));
        tbl.push_back(mk(0,0,2'b00,1,0,0,8'h00, 1,1,2'b00,C_ZERO_NEXT,0));
        tbl.push_back(mk(0,0,2'b00,0,0,1,8'h00, 1,0,C_SO_V13,8'h00,0));
        // scan-in 1,0,1,0 / 0,1,1,0 with functional controls ignored
        tbl.push_back(mk(0,1,2'b01,1,1,0,8'h00, 1,0,2'b00,8'h01,0));
        tbl.push_back(mk(0,1,2'b10,1,0,1,8'hAA, 1,0,2'b00,8'h12,0));
        tbl.push_back(mk(0,1,2'b11,1,1,0,8'h00, 1,0,2'b00,8'h35,0));
        tbl.push_back(mk(0,1,2'b00,1,0,0,8'h00, 1,0,2'b00,8'h6A,1));
        tbl.push_back(mk(0,0,2'b00,0,0,0,8'h00, 1,0,2'b01,8'h6A,0));
        // unload C3
        tbl.push_back(mk(0,0,2'b00,0,0,1,8'hC3, 1,0,2'b01,8'hC3,0));
        tbl.push_back(mk(0,1,2'b00,0,0,0,8'h00, 1,0,2'b10,8'h86,0));
        tbl.push_back(mk(0,1,2'b00,0,0,0,8'h00, 1,0,2'b10,8'h0C,0));
        tbl.push_back(mk(0,1,2'b00,0,0,0,8'h00, 1,0,2'b01,8'h08,0));
        tbl.push_back(mk(0,1,2'b00,0,0,0,8'h00, 1,0,2'b01,8'h00,1));
        // partial burst, functional resume, then a fresh full burst
        tbl.push_back(mk(0,1,2'b11,0,0,0,8'h00, 1,0,2'b00,8'h11,0));
        tbl.push_back(mk(0,1,2'b11,0,0,0,8'h00, 1,0,2'b00,8'h33,0));
        tbl.push_back(mk(0,0,2'b00,0,0,0,8'h00, 1,0,2'b00,8'h33,0));
        tbl.push_back(mk(0,0,2'b00,1,1,0,8'h00, 1,0,2'b00,8'h34,0));
        tbl.push_back(mk(0,1,2'b00,0,0,0,8'h00, 1,0,2'b00,8'h68,0));
        tbl.push_back(mk(0,1,2'b00,0,0,0,8'h00, 1,0,2'b01,8'hC0,0));
        tbl.push_back(mk(0,1,2'b00,0,0,0,8'h00, 1,0,2'b10,8'h80,0));
        tbl.push_back(mk(0,1,2'b00,0,0,0,8'h00, 1,0,2'b10,8'h00,1));
        // reset after 3 shifts, scan_en held high through it
        tbl.push_back(mk(0,1,2'b11,0,0,0,8'h00, 1,0,2'b00,8'h11,0));
        tbl.push_back(mk(0,1,2'b11,0,0,0,8'h00, 1,0,2'b00,8'h33,0));
        tbl.push_back(mk(0,1,2'b11,0,0,0,8'h00, 1,0,2'b00,8'h77,0));
        tbl.push_back(mk(1,1,2'b11,0,0,0,8'h00, 1,0,2'b00,8'h00,0));
        tbl.push_back(mk(0,1,2'b11,0,0,0,8'h00, 1,0,2'b00,8'h11,0));
        tbl.push_back(mk(0,1,2'b11,0,0,0,8'h00, 1,0,2'b00,8'h33,0));
        tbl.push_back(mk(0,1,2'b11,0,0,0,8'h00, 1,0,2'b00,8'h77,0));
        tbl.push_back(mk(0,1,2'b11,0,0,0,8'h00, 1,0,2'b00,8'hFF,1));
        tbl.push_back(mk(0,0,2'b00,1,1,0,8'h00, 1,1,2'b11,C_TOP_NEXT,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].se, tbl[i].si, tbl[i].ce, tbl[i].ud, tbl[i].ld, tbl[i].lv);
            sb.push_back('{cnt: tbl[i].e_cnt, sd: tbl[i].e_sd, idx: i});
            #4;
            if (tbl[i].pre) begin
                chk("tc", i, 32'(tc), 32'(tbl[i].e_tc));
                chk("scan_out", i, 32'(scan_out), 32'(tbl[i].e_so));
            end
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", i, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("count", e.idx, 32'(count), 32'(e.cnt));
                chk("shift_done", e.idx, 32'(shift_done), 32'(e.sd));
            end
        end

        // continuous burst: pulses every CHAIN_LEN shifts
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00);
        first_at  = -1;
        second_at = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (shift_done) begin
                if (first_at < 0)       first_at  = c;
                else if (second_at < 0) second_at = c;
            end
        end
        chk("burst_first_pulse", 0, 32'(first_at), 32'd4);
        chk("burst_second_pulse", 0, 32'(second_at), 32'd8);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        chk("burst_count", 0, 32'(count), 32'hF0);
        chk("burst_done_low", 0, 32'(shift_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
